// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer for the 64-point FFT core.
// A sample stream is written into a two-bank ping-pong buffer. Each full bank is sent to
// the FFT as one gap-free 64-cycle burst. The number of frames in flight is capped, and the
// returned bins are indexed 0..63 with a per-frame completion pulse.
//
// Handshake: a sample transfers on a rising edge where s_valid and s_ready are both high.
// s_ready depends only on registered bank state and RST, never on s_valid. fft_valid_a and
// fft_valid_o carry no back-pressure: every cycle they are high carries one word.
module fft64_frame_ctrl #(
   parameter int width        = 11,
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_W        = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              s_valid,
   input  logic [width-1:0]  s_data,
   output logic              s_ready,
   output logic              fft_valid_a,
   output logic [width-1:0]  fft_ar,
   output logic [width-1:0]  fft_ai,
   input  logic              fft_valid_o,
   input  logic [width-1:0]  fft_xr,
   input  logic [width-1:0]  fft_xi,
   output logic              bin_valid,
   output logic [5:0]        bin_idx,
   output logic [width-1:0]  bin_re,
   output logic [width-1:0]  bin_im,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              busy,
   output logic              dbg_rd_state
);

   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_READING} bank_st_e;
   typedef enum logic {RD_IDLE, RD_BURST} rd_st_e;

   localparam logic [1:0] MAX_IF = 2'(MAX_INFLIGHT);

   bank_st_e         bank_q [0:1];
   bank_st_e         bank_d [0:1];
   logic             wr_bank_q, wr_bank_d;
   logic [5:0]       wr_idx_q, wr_idx_d;
   logic             rd_bank_q, rd_bank_d;
   logic [5:0]       rd_addr_q, rd_addr_d;
   rd_st_e           rd_q, rd_d;
   logic [1:0]       inflight_q, inflight_d;
   logic [5:0]       out_cnt_q, out_cnt_d;
   logic [width-1:0] mem_q [0:127];

   logic             fft_valid_a_q;
   logic [width-1:0] fft_ar_q;
   logic             bin_valid_q, frame_done_q;
   logic [5:0]       bin_idx_q;
   logic [width-1:0] bin_re_q, bin_im_q;
   logic [CNT_W-1:0] frame_cnt_q;

   logic             accept, launch, last_issue, rd_en, take, wrap;
   logic [5:0]       rd_addr;

   // Write side is open while the target bank is not yet full or being read out.
   always_comb begin
      s_ready = 1'b0;
      if (!RST)
         s_ready = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
      accept = s_valid && s_ready;
   end

   // Read FSM: launch a full bank when a frame slot is free, then issue 64 addresses.
   always_comb begin
      rd_d       = rd_q;
      rd_addr_d  = rd_addr_q;
      rd_bank_d  = rd_bank_q;
      launch     = 1'b0;
      last_issue = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = rd_addr_q;
      case (rd_q)
         RD_IDLE: begin
            if (bank_q[rd_bank_q] == BANK_FULL && inflight_q < MAX_IF) begin
               launch    = 1'b1;
               rd_en     = 1'b1;
               rd_addr   = 6'd0;
               rd_addr_d = 6'd1;
               rd_d      = RD_BURST;
            end
         end
         RD_BURST: begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + 6'd1;
            if (rd_addr_q == 6'd63) begin
               // Last address issued: bank is writable and a new launch may follow next cycle.
               last_issue = 1'b1;
               rd_d       = RD_IDLE;
               rd_bank_d  = ~rd_bank_q;
               rd_addr_d  = 6'd0;
            end
         end
         default: rd_d = RD_IDLE;
      endcase
   end

   // Bank life cycle and write pointer; the three events never target the same bank.
   always_comb begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      if (accept) begin
         wr_idx_d = wr_idx_q + 6'd1;
         if (wr_idx_q == 6'd63) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            bank_d[wr_bank_q] = BANK_FILLING;
         end
      end
      if (launch)
         bank_d[rd_bank_q] = BANK_READING;
      if (last_issue)
         bank_d[rd_bank_q] = BANK_EMPTY;
   end

   // Returned-bin counter and in-flight bookkeeping; outputs with no frame outstanding are dropped.
   always_comb begin
      take       = fft_valid_o && (inflight_q != 2'd0);
      wrap       = take && (out_cnt_q == 6'd63);
      out_cnt_d  = take ? out_cnt_q + 6'd1 : out_cnt_q;
      inflight_d = inflight_q;
      if (launch && !wrap)
         inflight_d = inflight_q + 2'd1;
      else if (wrap && !launch)
         inflight_d = inflight_q - 2'd1;
   end

   // Control state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bank_q[0]  <= BANK_EMPTY;
         bank_q[1]  <= BANK_EMPTY;
         wr_bank_q  <= 1'b0;
         wr_idx_q   <= 6'd0;
         rd_bank_q  <= 1'b0;
         rd_addr_q  <= 6'd0;
         rd_q       <= RD_IDLE;
         inflight_q <= 2'd0;
         out_cnt_q  <= 6'd0;
      end else begin
         bank_q[0]  <= bank_d[0];
         bank_q[1]  <= bank_d[1];
         wr_bank_q  <= wr_bank_d;
         wr_idx_q   <= wr_idx_d;
         rd_bank_q  <= rd_bank_d;
         rd_addr_q  <= rd_addr_d;
         rd_q       <= rd_d;
         inflight_q <= inflight_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   // Sample storage; contents need no reset since bank state gates every read.
   always_ff @(posedge CLK) begin
      if (accept)
         mem_q[{wr_bank_q, wr_idx_q}] <= s_data;
   end

   // One-cycle read: the word addressed in cycle t appears on the FFT input in t+1.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fft_valid_a_q <= 1'b0;
         fft_ar_q      <= '0;
      end else begin
         fft_valid_a_q <= rd_en;
         if (rd_en)
            fft_ar_q <= mem_q[{rd_bank_q, rd_addr}];
      end
   end

   // Registered bin output stage with frame completion pulse and frame counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bin_valid_q  <= 1'b0;
         bin_idx_q    <= 6'd0;
         bin_re_q     <= '0;
         bin_im_q     <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         bin_valid_q  <= take;
         frame_done_q <= wrap;
         if (take) begin
            bin_idx_q <= out_cnt_q;
            bin_re_q  <= fft_xr;
            bin_im_q  <= fft_xi;
         end
         if (wrap)
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
   end

   assign fft_valid_a  = fft_valid_a_q;
   assign fft_ar       = fft_ar_q;
   assign fft_ai       = '0;
   assign bin_valid    = bin_valid_q;
   assign bin_idx      = bin_idx_q;
   assign bin_re       = bin_re_q;
   assign bin_im       = bin_im_q;
   assign frame_done   = frame_done_q;
   assign frame_cnt    = frame_cnt_q;
   assign busy         = (rd_q == RD_BURST) || (inflight_q != 2'd0);
   assign dbg_rd_state = rd_q;

endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Bench for fft64_frame_ctrl. A stub FFT returns one random frame per burst it has fully
// received; expected FFT-input words and expected bins are queued and checked by monitors.
module tb_fft64_frame_ctrl;

   localparam int W = 11;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          s_valid, s_ready;
   logic [W-1:0]  s_data;
   logic          fft_valid_a;
   logic [W-1:0]  fft_ar, fft_ai;
   logic          fft_valid_o;
   logic [W-1:0]  fft_xr, fft_xi;
   logic          bin_valid, frame_done, busy, dbg_rd_state;
   logic [5:0]    bin_idx;
   logic [W-1:0]  bin_re, bin_im;
   logic [15:0]   frame_cnt;

   fft64_frame_ctrl #(.width(W), .MAX_INFLIGHT(2), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .fft_valid_a(fft_valid_a), .fft_ar(fft_ar), .fft_ai(fft_ai),
      .fft_valid_o(fft_valid_o), .fft_xr(fft_xr), .fft_xi(fft_xi),
      .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
      .dbg_rd_state(dbg_rd_state)
   );

   // Clock and cycle counter.
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc++;

   int total = 0;
   int bad   = 0;

   // Scoreboard state.
   logic [W-1:0] exp_ar_q[$];
   logic [59:0]  exp_bin_q[$];     // {expected cycle[31:0], idx[5:0], re, im}
   int           frame_q[$];       // cycles at which the stub finished receiving a frame
   int           burst_start_q[$];
   int           done_cyc_q[$];    // cycles at which the stub drove bin 63
   int           ar_beat = 0, ar_run = 0, bin_seen = 0, done_pulses = 0;
   logic [15:0]  model_frames = '0;

   // Stub FFT controls: budget -1 = unlimited, 0 = hold outputs.
   int stub_budget = 0, stub_delay = 0, stub_gap = 0, stub_spurious = 0, out_idx = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic report_unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
   endtask

   // FFT-input monitor: data order, zero imag part, gap-free whole bursts.
   always @(negedge CLK) begin
      if (fft_valid_a) begin
         if (ar_beat == 0) burst_start_q.push_back(cyc);
         if (exp_ar_q.size() == 0) report_unexpected("fft_ar");
         else check("fft_ar", fft_ar, exp_ar_q.pop_front());
         check("fft_ai", fft_ai, 0);
         ar_beat++;
         ar_run++;
         if (ar_beat == 64) begin
            frame_q.push_back(cyc);
            ar_beat = 0;
         end
      end else if (ar_run > 0) begin
         check("burst_len_mod64", ar_run % 64, 0);
         ar_run = 0;
      end
   end

   // Bin monitor: latency, index, data, completion pulse and frame count.
   always @(negedge CLK) begin
      logic [59:0] e;
      if (bin_valid) begin
         bin_seen++;
         if (frame_done) done_pulses++;
         if (exp_bin_q.size() == 0) report_unexpected("bin");
         else begin
            e = exp_bin_q.pop_front();
            check("bin_cycle", cyc, e[59:28]);
            check("bin_idx", bin_idx, e[27:22]);
            check("bin_re", bin_re, e[21:11]);
            check("bin_im", bin_im, e[10:0]);
            check("frame_done", frame_done, longint'(e[27:22] == 6'd63));
            if (e[27:22] == 6'd63) model_frames = model_frames + 16'd1;
            check("frame_cnt", frame_cnt, model_frames);
         end
      end else if (frame_done) begin
         report_unexpected("frame_done");
      end
   end

   // Stub FFT: returns a frame once fully received and its delay has passed.
   always @(posedge CLK) begin
      #2;
      if (stub_spurious > 0) begin
         fft_valid_o = 1'b1;
         fft_xr = W'($urandom);
         fft_xi = W'($urandom);
         stub_spurious--;
      end else if (frame_q.size() > 0 && cyc >= frame_q[0] + stub_delay && stub_budget != 0 &&
                   $urandom_range(0, 99) >= stub_gap) begin
         fft_valid_o = 1'b1;
         fft_xr = W'($urandom);
         fft_xi = W'($urandom);
         exp_bin_q.push_back({32'(cyc + 1), 6'(out_idx), fft_xr, fft_xi});
         if (out_idx == 63) begin
            done_cyc_q.push_back(cyc);
            void'(frame_q.pop_front());
            out_idx = 0;
         end else begin
            out_idx++;
         end
         if (stub_budget > 0) stub_budget--;
      end else begin
         fft_valid_o = 1'b0;
      end
   end

   // Driver: offer samples until n accepted or max_cyc cycles elapse. Called at posedge+1.
   task automatic send(input int n, input int max_cyc, input bit ramp, input int vgap,
                       output int acc, output int stalls);
      int k = 0;
      acc = 0;
      stalls = 0;
      while (acc < n && k < max_cyc) begin
         if (vgap > 0 && $urandom_range(0, 99) < vgap) s_valid = 1'b0;
         else s_valid = 1'b1;
         s_data = ramp ? W'(acc) : W'($urandom_range(0, 2047));
         @(negedge CLK);
         if (s_valid && s_ready) begin
            exp_ar_q.push_back(s_data);
            acc++;
         end else if (s_valid) begin
            stalls++;
         end
         @(posedge CLK);
         #1;
         k++;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_all_empty(input string name, input int max_cyc);
      int k = 0;
      while ((exp_ar_q.size() != 0 || frame_q.size() != 0 || exp_bin_q.size() != 0) &&
             k < max_cyc) begin
         @(posedge CLK);
         #1;
         k++;
      end
      wait_cycles(3);
      check(name, exp_ar_q.size() + frame_q.size() + exp_bin_q.size(), 0);
   endtask

   task automatic flush_model();
      exp_ar_q.delete();
      exp_bin_q.delete();
      frame_q.delete();
      ar_beat = 0;
      ar_run = 0;
      out_idx = 0;
      model_frames = '0;
   endtask

   // Watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int acc, stalls, b0, d0, s0, target, c, k;
      s_valid = 1'b0;
      s_data = '0;
      fft_valid_o = 1'b0;
      fft_xr = '0;
      fft_xi = '0;

      // Reset values.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_s_ready", s_ready, 0);
      check("rst_valid_a", fft_valid_a, 0);
      check("rst_ar", fft_ar, 0);
      check("rst_bin_valid", bin_valid, 0);
      check("rst_bin_idx", bin_idx, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_rd_state, 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_s_ready", s_ready, 1);
      @(posedge CLK);
      #1;

      // Ramp 0..63 with outputs held: one contiguous burst, frame stays in flight.
      stub_budget = 0;
      b0 = burst_start_q.size();
      send(64, 200, 1'b1, 0, acc, stalls);
      wait_cycles(80);
      check("t1_bursts", burst_start_q.size() - b0, 1);
      check("t1_ar_drained", exp_ar_q.size(), 0);
      check("t1_busy_inflight", busy, 1);
      stub_delay = 10;
      stub_budget = -1;
      wait_all_empty("t1_drain", 300);
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_idle", busy, 0);

      // 128 back-to-back samples with echo: bursts 64 apart, no back-pressure.
      b0 = burst_start_q.size();
      send(128, 400, 1'b0, 0, acc, stalls);
      check("t2_stalls", stalls, 0);
      wait_all_empty("t2_drain", 500);
      check("t2_bursts", burst_start_q.size() - b0, 2);
      if (burst_start_q.size() - b0 >= 2)
         check("t2_spacing", burst_start_q[b0 + 1] - burst_start_q[b0], 64);
      check("t2_frame_cnt", frame_cnt, 3);

      // In-flight cap: outputs held, 300 offered.
      stub_budget = 0;
      stub_delay = 0;
      b0 = burst_start_q.size();
      send(300, 400, 1'b0, 0, acc, stalls);
      check("t3_accepted", acc, 256);
      check("t3_s_ready_low", s_ready, 0);
      wait_cycles(100);
      check("t3_bursts_capped", burst_start_q.size() - b0, 2);
      d0 = done_cyc_q.size();
      stub_budget = -1;
      k = 0;
      while ((done_cyc_q.size() <= d0 || burst_start_q.size() <= b0 + 2) && k < 300) begin
         wait_cycles(1);
         k++;
      end
      if (done_cyc_q.size() > d0 && burst_start_q.size() > b0 + 2)
         check("t3_third_launch", burst_start_q[b0 + 2], done_cyc_q[d0] + 2);
      else
         check("t3_third_launch_timeout", k, -1);
      wait_all_empty("t3_drain", 1000);

      // Random gaps on both sides.
      stub_gap = 50;
      stub_delay = 3;
      s0 = done_pulses;
      send(64, 400, 1'b0, 30, acc, stalls);
      wait_all_empty("t4_drain", 1000);
      check("t4_done_pulses", done_pulses - s0, 1);
      stub_gap = 0;

      // Reset during burst cycle 30.
      stub_budget = 0;
      b0 = burst_start_q.size();
      send(80, 300, 1'b0, 0, acc, stalls);
      if (burst_start_q.size() > b0) begin
         target = burst_start_q[b0] + 29;
         check("t5_not_late", longint'(cyc <= target), 1);
         while (cyc < target) wait_cycles(1);
         RST = 1'b1;
         @(posedge CLK);
         #1;
         flush_model();
         RST = 1'b0;
         @(negedge CLK);
         check("t5_valid_a_low", fft_valid_a, 0);
         check("t5_busy", busy, 0);
         check("t5_s_ready", s_ready, 1);
         check("t5_frame_cnt", frame_cnt, 0);
         @(posedge CLK);
         #1;
      end else begin
         check("t5_no_burst", burst_start_q.size() - b0, 1);
      end
      stub_budget = -1;
      stub_delay = 5;
      send(64, 200, 1'b0, 0, acc, stalls);
      wait_all_empty("t5_drain", 400);
      check("t5_frame_cnt_after", frame_cnt, 1);

      // Frame completion and bank FULL in the same cycle with the cap reached.
      stub_budget = 0;
      stub_delay = 0;
      b0 = burst_start_q.size();
      send(191, 400, 1'b0, 0, acc, stalls);
      check("t6_accepted", acc, 191);
      wait_cycles(80);
      check("t6_bursts", burst_start_q.size() - b0, 2);
      stub_budget = 63;
      k = 0;
      while (stub_budget != 0 && k < 200) begin
         wait_cycles(1);
         k++;
      end
      wait_cycles(3);
      stub_budget = 1;
      s_valid = 1'b1;
      s_data = W'($urandom_range(0, 2047));
      @(negedge CLK);
      check("t6_s_ready", s_ready, 1);
      if (s_ready) exp_ar_q.push_back(s_data);
      c = cyc;
      @(posedge CLK);
      #1;
      s_valid = 1'b0;
      k = 0;
      while (burst_start_q.size() <= b0 + 2 && k < 20) begin
         wait_cycles(1);
         k++;
      end
      if (burst_start_q.size() > b0 + 2)
         check("t6_launch", burst_start_q[b0 + 2], c + 2);
      else
         check("t6_launch_timeout", k, -1);
      stub_budget = -1;
      wait_all_empty("t6_drain", 800);

      // FFT outputs with nothing in flight are ignored and do not move the bin counter.
      s0 = bin_seen;
      stub_spurious = 6;
      wait_cycles(12);
      check("t7_ignored", bin_seen - s0, 0);
      check("t7_busy", busy, 0);
      send(64, 200, 1'b0, 0, acc, stalls);
      wait_all_empty("t7_drain", 400);
      check("t7_bins", bin_seen - s0, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
